// File: rtl/turn_scheduler.sv
// turn_scheduler: round-based turn sequencer that grants one unit at a time.
// Define TURN_TIMEOUT_EN to enable the enemy-turn watchdog.
module turn_scheduler #(
    parameter int NUM_UNITS     = 4,
    parameter int NUM_PLAYER    = 2,
    parameter int POS_W         = 9,
    parameter int IDX_W         = 2,
    parameter int ENEMY_TIMEOUT = 1048576
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_UNITS-1:0]       unit_alive,
    input  logic [NUM_UNITS*POS_W-1:0] unit_pos,
    input  logic                       end_turn,
    input  logic                       act_done,
    output logic [NUM_UNITS-1:0]       act_grant,
    output logic [IDX_W-1:0]           active_idx,
    output logic [POS_W-1:0]           action_pos,
    output logic [1:0]                 phase,
    output logic [7:0]                 round_cnt,
    output logic                       winner,
    output logic                       turn_start
);

    typedef enum logic [1:0] {IDLE, SELECT, GRANT, OVER} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_UNITS - 1);
    localparam logic [IDX_W-1:0] FIRST_ENEMY = IDX_W'(NUM_PLAYER);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] idx_adv;
    logic [7:0]       round_nxt;
    logic [7:0]       round_adv;
    logic [1:0]       phase_nxt;
    logic             armed;
    logic             player_any;
    logic             enemy_any;
    logic             cur_alive;
    logic             is_enemy;
    logic             wd_hit;
    logic             term;
    logic [POS_W-1:0] pos_arr [NUM_UNITS];

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            pos_arr[i] = unit_pos[i*POS_W +: POS_W];
        end
    end

    assign player_any = |unit_alive[NUM_PLAYER-1:0];
    assign enemy_any  = |unit_alive[NUM_UNITS-1:NUM_PLAYER];
    assign cur_alive  = unit_alive[active_idx];
    assign is_enemy   = active_idx >= FIRST_ENEMY;

    assign idx_adv   = (active_idx == LAST_IDX) ? '0 : active_idx + 1'b1;
    assign round_adv = (active_idx == LAST_IDX && round_cnt != 8'hFF)
                     ? round_cnt + 8'd1 : round_cnt;

`ifdef TURN_TIMEOUT_EN
    localparam int WD_W = $clog2(ENEMY_TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ENEMY_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;

    // Cleared outside GRANT so every turn starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state != GRANT) begin
            wd_cnt <= '0;
        end else if (is_enemy) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_hit = (state == GRANT) && is_enemy && (wd_cnt == WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    assign term = !cur_alive || wd_hit || (is_enemy ? act_done : end_turn);

    always_comb begin
        state_nxt = state;
        idx_nxt   = active_idx;
        round_nxt = round_cnt;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    state_nxt = SELECT;
                    idx_nxt   = '0;
                    round_nxt = 8'd1;
                end
            end
            SELECT: begin
                if (!player_any || !enemy_any) begin
                    state_nxt = OVER;
                end else if (cur_alive) begin
                    state_nxt = GRANT;
                end else begin
                    idx_nxt   = idx_adv;
                    round_nxt = round_adv;
                end
            end
            GRANT: begin
                if (term) begin
                    state_nxt = SELECT;
                    idx_nxt   = idx_adv;
                    round_nxt = round_adv;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_comb begin
        case (state_nxt)
            IDLE:    phase_nxt = 2'b00;
            OVER:    phase_nxt = 2'b11;
            default: phase_nxt = (idx_nxt < FIRST_ENEMY) ? 2'b01 : 2'b10;
        endcase
    end

    // A start coinciding with reset release is dropped via the armed flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            act_grant  <= '0;
            active_idx <= '0;
            action_pos <= '0;
            phase      <= 2'b00;
            round_cnt  <= 8'd0;
            winner     <= 1'b0;
            turn_start <= 1'b0;
        end else begin
            armed      <= 1'b1;
            state      <= state_nxt;
            active_idx <= idx_nxt;
            round_cnt  <= round_nxt;
            phase      <= phase_nxt;
            act_grant  <= (state_nxt == GRANT)
                        ? (NUM_UNITS'(1) << idx_nxt) : '0;
            turn_start <= (state == SELECT) && (state_nxt == GRANT);
            if (state == SELECT && state_nxt == OVER) begin
                winner <= player_any;
            end
            if (state != OVER) begin
                action_pos <= pos_arr[idx_nxt];
            end
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a rule-level reference model
// compared against the DUT on every falling clock edge.
module tb_turn_scheduler;

    localparam int NU = 4;
    localparam int NP = 2;
    localparam int PW = 9;
    localparam int IW = 2;
`ifdef TURN_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1048576;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          end_turn = 1'b0;
    logic          act_done = 1'b0;
    logic [NU-1:0] unit_alive = '1;
    logic [NU*PW-1:0] unit_pos = {9'd73, 9'd52, 9'd31, 9'd10};

    logic [NU-1:0] act_grant;
    logic [IW-1:0] active_idx;
    logic [PW-1:0] action_pos;
    logic [1:0]    phase;
    logic [7:0]    round_cnt;
    logic          winner;
    logic          turn_start;

    int n_tests = 0;
    int n_fail  = 0;

    turn_scheduler #(
        .NUM_UNITS(NU), .NUM_PLAYER(NP), .POS_W(PW),
        .IDX_W(IW), .ENEMY_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .unit_alive(unit_alive), .unit_pos(unit_pos),
        .end_turn(end_turn), .act_done(act_done),
        .act_grant(act_grant), .active_idx(active_idx),
        .action_pos(action_pos), .phase(phase),
        .round_cnt(round_cnt), .winner(winner),
        .turn_start(turn_start)
    );

    always #5 clk = ~clk;

    // model: mode 0 idle, 1 scanning, 2 unit acting, 3 game over
    int m_mode, m_idx, m_round, m_wd, m_pos;
    bit m_win, m_ts, m_armed;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_round = 0; m_wd = 0; m_pos = 0;
        m_win = 0; m_ts = 0; m_armed = 0;
    endtask

    task automatic model_next_unit();
        m_idx = (m_idx + 1) % NU;
        if (m_idx == 0 && m_round < 255) m_round++;
    endtask

    task automatic model_step();
        int  prev = m_mode;
        bit  p = 0, e = 0, done;
        for (int i = 0; i < NU; i++)
            if (unit_alive[i]) begin
                if (i < NP) p = 1; else e = 1;
            end
        m_ts = 0;
        case (m_mode)
            0: if (start && m_armed) begin
                m_mode = 1; m_idx = 0; m_round = 1;
            end
            1: if (!p || !e) begin
                m_mode = 3; m_win = p;
            end else if (unit_alive[m_idx]) begin
                m_mode = 2; m_ts = 1; m_wd = 0;
            end else begin
                model_next_unit();
            end
            2: begin
                done = !unit_alive[m_idx] || (m_idx < NP ? end_turn : act_done);
`ifdef TURN_TIMEOUT_EN
                if (m_idx >= NP) begin
                    if (m_wd == TO - 1) done = 1;
                    m_wd++;
                end
`endif
                if (done) begin
                    m_mode = 1; model_next_unit();
                end
            end
            default: ;
        endcase
        m_armed = 1;
        if (prev != 3) m_pos = int'(unit_pos[m_idx*PW +: PW]);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("grant", int'(act_grant), (m_mode == 2) ? (1 << m_idx) : 0);
            chk("phase", int'(phase),
                (m_mode == 0) ? 0 : (m_mode == 3) ? 3 : (m_idx < NP) ? 1 : 2);
            chk("idx", int'(active_idx), m_idx);
            chk("round", int'(round_cnt), m_round);
            chk("pos", int'(action_pos), m_pos);
            chk("winner", int'(winner), int'(m_win));
            chk("turn_start", int'(turn_start), int'(m_ts));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_end();
        end_turn = 1'b1; tick(); end_turn = 1'b0;
    endtask

    task automatic pulse_done();
        act_done = 1'b1; tick(); act_done = 1'b0;
    endtask

    task automatic wait_grant(input int g, input string name, output int n);
        n = 0;
        while (int'(act_grant) != g && n < 20) begin
            tick(); n++;
        end
        chk(name, int'(act_grant), g);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, int'(act_grant), 0);
        chk({tag, "_idx"}, int'(active_idx), 0);
        chk({tag, "_pos"}, int'(action_pos), 0);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_round"}, int'(round_cnt), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_ts"}, int'(turn_start), 0);
    endtask

    int n;

    initial begin
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst");
        tick(); tick();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("start_at_release", int'(phase), 0);
        tick();

        pulse_start();
        chk("select_phase", int'(phase), 1);
        chk("select_grant", int'(act_grant), 0);
        tick();
        chk("g0", int'(act_grant), 1);
        chk("g0_ts", int'(turn_start), 1);
        chk("g0_round", int'(round_cnt), 1);
        chk("g0_pos", int'(action_pos), 10);
        pulse_end();
        wait_grant(2, "g1", n);
        chk("g1_gap", n, 1);
        chk("g1_phase", int'(phase), 1);
        pulse_done(); tick(); tick();
        chk("done_ignored", int'(act_grant), 2);
        pulse_end();
        wait_grant(4, "g2", n);
        chk("g2_phase", int'(phase), 2);
        pulse_end(); tick();
        chk("end_ignored", int'(act_grant), 4);
        pulse_done();
        wait_grant(8, "g3", n);
        chk("g3_phase", int'(phase), 2);
        pulse_done();
        wait_grant(1, "g0_again", n);
        chk("wrap_round", int'(round_cnt), 2);
        chk("wrap_phase", int'(phase), 1);

        unit_alive = 4'b1011;
        pulse_end();
        wait_grant(2, "b_g1", n);
        pulse_end();
        wait_grant(8, "skip_g3", n);
        chk("skip_gap", n + 1, 3);
        pulse_done();
        wait_grant(1, "b_g0", n);
        chk("b_round", int'(round_cnt), 3);
        pulse_end();
        wait_grant(2, "b_g1b", n);
        unit_alive = 4'b1101;
        end_turn = 1'b1; tick(); end_turn = 1'b0;
        wait_grant(4, "single_adv", n);
        chk("single_adv_gap", n, 1);
        unit_pos[2*PW +: PW] = 9'd99;
        tick();
        chk("pos_track", int'(action_pos), 99);
        pulse_done();
        wait_grant(8, "c_g3", n);
        unit_alive = 4'b0001;
        tick();
        chk("kill_select", int'(act_grant), 0);
        tick();
        chk("over_phase", int'(phase), 3);
        chk("over_winner", int'(winner), 1);
        chk("over_round", int'(round_cnt), 4);
        pulse_start(); tick();
        chk("over_start_ign", int'(phase), 3);
        chk("over_grant", int'(act_grant), 0);

        rst = 1'b0;
        #1 chk_reset_vals("async_over");
        tick();
        @(posedge clk); #1 rst = 1'b1;
        tick();
        unit_alive = 4'b1111;
        pulse_start();
        wait_grant(1, "d_g0", n);
        pulse_end();
        wait_grant(2, "d_g1", n);
        pulse_end();
        wait_grant(4, "d_g2", n);
        n = 0;
        while (int'(act_grant) == 4 && n < 1000) begin
            n++; tick();
        end
`ifdef TURN_TIMEOUT_EN
        chk("timeout_len", n, 16);
        wait_grant(8, "timeout_next", n);
`else
        chk("hold_len", n, 1000);
        chk("hold_grant", int'(act_grant), 4);
`endif
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_grant");
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
